// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-wide transmit FIFO between the processor output port and the UART
// transmit engine. Processor write strobes push bytes into a circular
// buffer. A three-state drain FSM (IDLE/SEND/BUSY) passes bytes to the
// engine one at a time using the engine's txRdy / load handshake.
// Fill level, full/empty and a sticky overflow flag are exported for the
// UART status register.
//
// Optional feature macro: TXF_LVL_IRQ_EN
//   When defined, a registered level interrupt txfIrq_o is added. It is high
//   while the fill level is at or below LOW_WATER.
//
// Parameters:
//   DEPTH      number of byte entries (power of two, 2..256)
//   ADDR_W     log2(DEPTH)
//   LOW_WATER  level-interrupt threshold in entries (0..DEPTH)
//
// Ports:
//   clk_i      single clock, all state changes on the rising edge
//   reset_i    synchronous active-high reset
//   wr_i       processor write strobe, one byte per high cycle
//   wrData_i   byte to enqueue
//   txRdy_i    transmit engine idle and ready for a byte
//   clrOvf_i   clears the sticky overflow flag
//   load_o     one-cycle pulse to the engine; txData_o is valid with it
//   txData_o   byte presented to the engine, held between loads
//   full_o     fill level equals DEPTH
//   empty_o    fill level equals zero
//   count_o    entries currently stored
//   ovf_o      sticky: a write arrived while full
//   txfIrq_o   level interrupt (only with TXF_LVL_IRQ_EN)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int LOW_WATER = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_i,
    input  logic [7:0]        wrData_i,
    input  logic              txRdy_i,
    input  logic              clrOvf_i,
    output logic              load_o,
    output logic [7:0]        txData_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              ovf_o
`ifdef TXF_LVL_IRQ_EN
    ,
    output logic              txfIrq_o
`endif
);

    // Elaboration-time sanity checks on the parameter set.
    if ((1 << ADDR_W) != DEPTH) begin : gBadAddrW
        $error("uart_tx_fifo: ADDR_W does not match DEPTH");
    end
    if (LOW_WATER < 0 || LOW_WATER > DEPTH) begin : gBadLowWater
        $error("uart_tx_fifo: LOW_WATER out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   DepthC  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PtrOneC = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CntOneC = (ADDR_W+1)'(1);

    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    state_e            state_q, state_d;
    logic [7:0]        txData_q, txData_d;
    logic              seenLow_q, seenLow_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;

    // Status decode from the explicit counter.
    assign full  = (count_q == DepthC);
    assign empty = (count_q == '0);

    // A write while full is dropped and only raises overflow, even when a
    // pop happens in the same cycle.
    assign push = wr_i && !full;

    // Drain FSM next-state logic. The BUSY state insists on seeing txRdy low
    // before accepting it high again, so an engine that drops txRdy a cycle
    // or two late cannot trigger a second load for the same transfer.
    always_comb begin
        state_d   = state_q;
        txData_d  = txData_q;
        seenLow_d = seenLow_q;
        load      = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && txRdy_i) begin
                    txData_d = mem_q[rp_q];
                    state_d  = SEND;
                end
            end
            SEND: begin
                load      = 1'b1;
                pop       = 1'b1;
                seenLow_d = 1'b0;
                state_d   = BUSY;
            end
            BUSY: begin
                if (!seenLow_q) begin
                    if (!txRdy_i) begin
                        seenLow_d = 1'b1;
                    end
                end else if (txRdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, fill level and overflow next-state logic.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            wp_d = wp_q + PtrOneC;
        end
        if (pop) begin
            rp_d = rp_q + PtrOneC;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntOneC;
            2'b01:   count_d = count_q - CntOneC;
            default: count_d = count_q;
        endcase
        // Set has priority over clear so an overflow is never lost.
        if (wr_i && full) begin
            ovf_d = 1'b1;
        end else if (clrOvf_i) begin
            ovf_d = 1'b0;
        end
    end

    // Byte storage. Not reset: clearing the counter and pointers discards
    // the contents logically.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wp_q] <= wrData_i;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            txData_q  <= 8'h00;
            seenLow_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            txData_q  <= txData_d;
            seenLow_q <= seenLow_d;
        end
    end

`ifdef TXF_LVL_IRQ_EN
    localparam logic [ADDR_W:0] LowWaterC = (ADDR_W+1)'(LOW_WATER);

    logic irq_q;

    // Computed from the next fill level so the flag lines up with count_o.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_q <= 1'b1;
        end else begin
            irq_q <= (count_d <= LowWaterC);
        end
    end

    assign txfIrq_o = irq_q;
`endif

    assign load_o   = load;
    assign txData_o = txData_q;
    assign full_o   = full;
    assign empty_o  = empty;
    assign count_o  = count_q;
    assign ovf_o    = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit FIFO between the processor output port and the UART transmit engine. Processor write strobes (the same `writes_0` strobe used for UART data writes) push `OUT_PORT` bytes into a circular buffer. A three-state drain FSM hands bytes to the transmit engine one at a time using its `TXRDY`/`LOAD` handshake. FULL/EMPTY/COUNT and a sticky overflow flag are exported for the UART status register, so software can queue bursts without polling `TXRDY` per byte.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, 2..256
- `ADDR_W`, 4, log2(`DEPTH`); must match `DEPTH`
- `LOW_WATER`, 4, level-interrupt threshold in entries, 0..`DEPTH`; used only with `TXF_LVL_IRQ_EN`

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `WR`  in  1  write strobe from processor (`writes_0`); one byte per high cycle
- `WR_DATA`  in  8  byte to enqueue (`OUT_PORT`)
- `TXRDY`  in  1  transmit engine idle and ready for a byte
- `LOAD`  out  1  one-cycle pulse to transmit engine; `TX_DATA` is valid in the same cycle
- `TX_DATA`  out  8  byte presented to transmit engine
- `FULL`  out  1  `COUNT == DEPTH`
- `EMPTY`  out  1  `COUNT == 0`
- `COUNT`  out  `ADDR_W+1`  entries currently stored
- `OVF`  out  1  sticky: a write arrived while `FULL`
- `CLR_OVF`  in  1  clears `OVF`
- `TXF_IRQ`  out  1  level interrupt; present only with `TXF_LVL_IRQ_EN`

## Operation
- Storage: `DEPTH`×8 array, write pointer `wp` and read pointer `rp` of `ADDR_W` bits, each wrapping modulo `DEPTH`.
- `COUNT` is an explicit `ADDR_W+1`-bit counter. `FULL` and `EMPTY` are decoded from it combinationally.
- Push: `WR && !FULL` stores `WR_DATA` at `wp`, then `wp` advances.
- A write while `FULL` is dropped. Nothing is stored, no pointer moves, and `OVF` is set.
- This drop rule holds even if a pop happens in the same cycle.
- Pop: occurs in the cycle `LOAD` is high; `rp` advances.
- `COUNT` per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `OVF`: `CLR_OVF` clears it. If a set event and `CLR_OVF` occur in the same cycle, the set wins.
- Drain FSM:
  - `IDLE`: if `!EMPTY && TXRDY`, register `TX_DATA <= mem[rp]` and go to `SEND`.
  - `SEND`: `LOAD=1` for exactly this cycle, pop, go to `BUSY`.
  - `BUSY`: wait for `TXRDY==0`, then for `TXRDY==1`, then go to `IDLE`. A one-bit `seen_low` flag tracks this; it clears on entry to `BUSY`.
- This sequencing prevents a second `LOAD` when the engine drops `TXRDY` late.
- The transmit engine must deassert `TXRDY` within 2 cycles of `LOAD`. This is a requirement on the engine, not checked here.
- `TX_DATA` holds its value between loads.

## Timing
- Reset values: `LOAD=0`, `TX_DATA=8'h00`, `COUNT=0`, `EMPTY=1`, `FULL=0`, `OVF=0`, `TXF_IRQ=1` (since `COUNT=0 <= LOW_WATER`), FSM=`IDLE`, `wp=rp=0`.
- Reset also discards the stored contents.
- `RESET` asserted mid-transfer (in `SEND` or `BUSY`) returns the FSM to `IDLE` on the next edge. No further `LOAD` is issued until a new write.
- Latency, empty FIFO with `TXRDY=1` and `WR` in cycle n:
  - cycle n+1: `COUNT=1`, `EMPTY=0`
  - cycle n+2: `LOAD=1`
  - cycle n+3: `COUNT=0`
- Back-to-back: minimum 3 cycles between consecutive `LOAD` pulses, plus the engine's busy time.
- `FULL`, `EMPTY` and `COUNT` update in the cycle after the causing edge. No combinational path from `WR` to any output.
- Pointer wrap from `DEPTH-1` to 0 is seamless: no bubble, no data loss.

## Configuration
- Macro `TXF_LVL_IRQ_EN`.
- Defined:
  - port `TXF_IRQ` exists
  - registered `TXF_IRQ <= (COUNT_next <= LOW_WATER)`, so it is valid one cycle after any count change
  - intended to be ORed into the processor interrupt alongside the UART ready interrupt
- Undefined: port and its register are absent; all other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles:
  - `COUNT=0`, `EMPTY=1`, `FULL=0`, `OVF=0`, `LOAD` never high
  - `TX_DATA=8'h00`, `TXF_IRQ=1` (macro on)
- Single byte, `TXRDY=1`: write `8'hA5` at cycle n → `LOAD=1` with `TX_DATA=8'hA5` at n+2; `EMPTY=1` at n+3.
- Burst of 20 writes, `DEPTH=16`, `TXRDY=0`:
  - `FULL=1` after the 16th write, `COUNT=16`
  - writes 17–20 dropped, `OVF=1`
  - then release `TXRDY` with an engine model (busy 10 cycles per byte): bytes 1–16 emerge in order, exactly one `LOAD` per `TXRDY` high→low→high cycle
- Wrap-around: 40 bytes `8'h00..8'h27` written at a rate sustaining `COUNT` between 1 and 15 → all 40 loaded in order, `OVF` stays 0.
- Simultaneous push/pop and `OVF` clear:
  - write during the `SEND` cycle at `COUNT=5` → `COUNT` stays 5
  - `CLR_OVF` and a full write in the same cycle → `OVF` remains 1
- `RESET` asserted during `BUSY` with `COUNT=3` → next cycle `COUNT=0`, FSM `IDLE`, no `LOAD` afterward.
- With `TXF_LVL_IRQ_EN` and `LOW_WATER=4`: `TXF_IRQ` falls when `COUNT` goes 4→5 and rises when it drains 5→4.
